// File: rtl/decoder_hold.sv
// decoder_hold: registered 2-to-4 decoder with a post-valid hold timer.
// Takes the encoder's (q, v) pair and produces a one-hot line vector d.
// d is stretched for HOLD_CYCLES cycles after v drops. The block also reports
// the last accepted code, a new-value strobe and a saturating event counter.
//
// Handshake: v is a plain qualifier with no back-pressure. Every rising edge
// with v=1 (and rst=0) accepts q, and the effect shows on d one cycle later.
module decoder_hold #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       q,
  input  logic             v,
  output logic [3:0]       d,
  output logic             busy,
  output logic             chg,
  output logic [1:0]       last_q,
  output logic [CNT_W-1:0] evt_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  // The counter is loaded with HOLD_CYCLES-1 on the falling-valid edge, so
  // that together with the expiry edge d stays up HOLD_CYCLES extra cycles.
  localparam logic [7:0]       HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic [3:0]       d_q, d_d;
  logic             chg_q, chg_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic [3:0]       dec;

  // Next-state, hold timer and accept-side updates.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    d_d     = d_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    chg_d   = 1'b0;
    accept  = 1'b0;
    dec     = 4'b0001 << q;

    case (state_q)
      IDLE: begin
        if (v) begin
          accept  = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (v) begin
          accept = 1'b1;
        end else begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (v) begin
          accept  = 1'b1;
          state_d = ACTIVE;
          hold_d  = '0;
        end else if (hold_q != '0) begin
          hold_d = hold_q - 8'd1;
        end else begin
          state_d = IDLE;
          d_d     = '0;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
        d_d     = '0;
      end
    endcase

    if (accept) begin
      d_d    = dec;
      code_d = q;
      // Strobe only when d moves to a different nonzero value. dec is never
      // zero, so coming out of IDLE always strobes.
      chg_d  = (dec != d_q);
      // The IDLE case also counts a code equal to the stale last_q.
      if (((q != code_q) || (state_q == IDLE)) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // State and output registers; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      d_q     <= '0;
      chg_q   <= 1'b0;
      code_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      d_q     <= d_d;
      chg_q   <= chg_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  assign d       = d_q;
  assign busy    = (state_q != IDLE);
  assign chg     = chg_q;
  assign last_q  = code_q;
  assign evt_cnt = cnt_q;

endmodule

// File: tb/tb_decoder_hold.sv
// tb_decoder_hold: directed checks of decoder_hold. Two instances share the
// stimulus: u_dut (CNT_W=8) and u_sat (CNT_W=2, for counter saturation).
module tb_decoder_hold;

  logic       clk;
  logic       rst;
  logic [1:0] q;
  logic       v;

  logic [3:0] d, d2;
  logic       busy, busy2;
  logic       chg, chg2;
  logic [1:0] last_q, last_q2;
  logic [7:0] evt_cnt;
  logic [1:0] evt_cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  decoder_hold #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .q(q), .v(v),
    .d(d), .busy(busy), .chg(chg), .last_q(last_q), .evt_cnt(evt_cnt)
  );

  decoder_hold #(.HOLD_CYCLES(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .q(q), .v(v),
    .d(d2), .busy(busy2), .chg(chg2), .last_q(last_q2), .evt_cnt(evt_cnt2)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ed, input logic eb,
                         input logic ec, input logic [1:0] el, input logic [7:0] ee);
    chk({tag, " d"},       {4'h0, d},       {4'h0, ed});
    chk({tag, " busy"},    {7'h0, busy},    {7'h0, eb});
    chk({tag, " chg"},     {7'h0, chg},     {7'h0, ec});
    chk({tag, " last_q"},  {6'h0, last_q},  {6'h0, el});
    chk({tag, " evt_cnt"}, evt_cnt,         ee);
  endtask

  // Drop v and let the hold timer expire (falling edge + 4 hold edges).
  task automatic drain();
    v = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    rst = 1'b1; v = 1'b1; q = 2'd3;

    // Reset holds everything at zero even with v=1.
    tick(); chk_out("rst1", 4'b0000, 0, 0, 2'd0, 8'd0);
    tick(); chk_out("rst2", 4'b0000, 0, 0, 2'd0, 8'd0);
    rst = 1'b0; v = 1'b0;
    tick(); chk_out("idle", 4'b0000, 0, 0, 2'd0, 8'd0);

    // Basic decode q=0..3 on consecutive edges.
    v = 1'b1;
    q = 2'd0; tick(); chk_out("dec0", 4'b0001, 1, 1, 2'd0, 8'd1);
    q = 2'd1; tick(); chk_out("dec1", 4'b0010, 1, 1, 2'd1, 8'd2);
    q = 2'd2; tick(); chk_out("dec2", 4'b0100, 1, 1, 2'd2, 8'd3);
    q = 2'd3; tick(); chk_out("dec3", 4'b1000, 1, 1, 2'd3, 8'd4);
    drain();   chk_out("drain1", 4'b0000, 0, 0, 2'd3, 8'd4);

    // v=0 in IDLE ignores q.
    q = 2'd2; v = 1'b0;
    tick(); chk_out("idle_ign", 4'b0000, 0, 0, 2'd3, 8'd4);

    // Hold stretch: one valid cycle, then d holds 5 cycles total.
    q = 2'd2; v = 1'b1;
    tick(); chk_out("hs_acc", 4'b0100, 1, 1, 2'd2, 8'd5);
    v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); chk_out($sformatf("hs_hold%0d", i), 4'b0100, 1, 0, 2'd2, 8'd5);
    end
    tick(); chk_out("hs_exp", 4'b0000, 0, 0, 2'd2, 8'd5);

    // Re-trigger in HOLD: no intermediate zero, chg pulses, +2 events.
    q = 2'd1; v = 1'b1;
    tick(); chk_out("rt_acc", 4'b0010, 1, 1, 2'd1, 8'd6);
    v = 1'b0;
    tick(); chk_out("rt_h0", 4'b0010, 1, 0, 2'd1, 8'd6);
    tick(); chk_out("rt_h1", 4'b0010, 1, 0, 2'd1, 8'd6);
    q = 2'd3; v = 1'b1;
    tick(); chk_out("rt_new", 4'b1000, 1, 1, 2'd3, 8'd7);
    drain();   chk_out("drain2", 4'b0000, 0, 0, 2'd3, 8'd7);

    // Same code repeated: one strobe, one event.
    q = 2'd1; v = 1'b1;
    tick(); chk_out("rep0", 4'b0010, 1, 1, 2'd1, 8'd8);
    for (int i = 1; i < 10; i++) begin
      tick(); chk_out($sformatf("rep%0d", i), 4'b0010, 1, 0, 2'd1, 8'd8);
    end
    drain();   chk_out("drain3", 4'b0000, 0, 0, 2'd1, 8'd8);

    // Reset during the 2nd HOLD cycle.
    q = 2'd0; v = 1'b1;
    tick(); chk_out("mh_acc", 4'b0001, 1, 1, 2'd0, 8'd9);
    v = 1'b0;
    tick(); chk_out("mh_h0", 4'b0001, 1, 0, 2'd0, 8'd9);
    rst = 1'b1;
    tick(); chk_out("mh_rst", 4'b0000, 0, 0, 2'd0, 8'd0);
    chk("mh_rst sat_cnt", {6'h0, evt_cnt2}, 8'd0);
    rst = 1'b0;
    tick(); chk_out("mh_idle", 4'b0000, 0, 0, 2'd0, 8'd0);

    // Saturation on the CNT_W=2 instance: alternate q=0/1 for 6 valid edges.
    v = 1'b1;
    for (int i = 0; i < 6; i++) begin
      q = 2'(i % 2);
      tick();
      chk($sformatf("sat%0d cnt", i), {6'h0, evt_cnt2}, (i < 3) ? 8'(i + 1) : 8'd3);
      chk($sformatf("sat%0d d", i), {4'h0, d2}, (i % 2 == 0) ? 8'h01 : 8'h02);
      chk($sformatf("sat%0d chg", i), {7'h0, chg2}, 8'h01);
    end
    chk("sat wide cnt", evt_cnt, 8'd6);
    chk("sat last_q", {6'h0, last_q2}, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
